// File: rtl/gpu_line_stepper_pkg.sv
// Shared GPU definitions for the line stepper: coordinate width, FSM states,
// next-pixel coordinate types and a small signed-step helper.
package gpu_line_stepper_pkg;

    localparam int COORD_W = 12;
    localparam int ERR_W   = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_STEP  = 2'd2
    } line_state_e;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef coord_t nextX_t;
    typedef coord_t nextY_t;

    // Adds a direction of -1/0/+1; the 12-bit result wraps with no saturation.
    function automatic coord_t step_coord(input coord_t c, input logic signed [1:0] s);
        return coord_t'(c + {{(COORD_W-2){s[1]}}, s});
    endfunction

endpackage

// File: rtl/gpu_line_stepper.sv
// Bresenham line stepper: loads endpoints on i_start, then emits one pixel per
// accepted i_step from (x0,y0) to (x1,y1) inclusive.
module gpu_line_stepper
    import gpu_line_stepper_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_nRst,
    input  logic                      i_start,
    input  logic signed [COORD_W-1:0] i_x0,
    input  logic signed [COORD_W-1:0] i_y0,
    input  logic signed [COORD_W-1:0] i_x1,
    input  logic signed [COORD_W-1:0] i_y1,
    input  logic                      i_step,
    output logic                      o_busy,
    output logic                      o_valid,
    output logic signed [COORD_W-1:0] o_lineX,
    output logic signed [COORD_W-1:0] o_lineY,
    output logic signed [COORD_W-1:0] o_nextLineX,
    output logic signed [COORD_W-1:0] o_nextLineY,
    output logic                      o_last,
    output logic                      o_done
);

    line_state_e         state_q, state_d;
    coord_t              x0_q, y0_q, x1_q, y1_q;
    coord_t              x0_d, y0_d, x1_d, y1_d;
    coord_t              cur_x_q, cur_y_q, cur_x_d, cur_y_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [COORD_W-1:0]  cnt_q, cnt_d;
    logic [COORD_W-1:0]  major_q, major_d, minor_q, minor_d;
    logic signed [1:0]   sx_q, sx_d, sy_q, sy_d;
    logic                x_major_q, x_major_d;
    logic                done_q, done_d;

    // Setup-time delta arithmetic on the registered endpoints.
    logic [COORD_W:0]    dx, dy, ndx, ndy;
    logic [COORD_W-1:0]  adx, ady, major_s, minor_s;
    logic signed [1:0]   sx_s, sy_s;
    logic                x_major_s;
    logic [ERR_W-1:0]    err_init;

    always_comb begin
        dx        = {x1_q[COORD_W-1], x1_q} - {x0_q[COORD_W-1], x0_q};
        dy        = {y1_q[COORD_W-1], y1_q} - {y0_q[COORD_W-1], y0_q};
        ndx       = -dx;
        ndy       = -dy;
        adx       = dx[COORD_W] ? ndx[COORD_W-1:0] : dx[COORD_W-1:0];
        ady       = dy[COORD_W] ? ndy[COORD_W-1:0] : dy[COORD_W-1:0];
        sx_s      = (dx == '0) ? 2'sb00 : (dx[COORD_W] ? 2'sb11 : 2'sb01);
        sy_s      = (dy == '0) ? 2'sb00 : (dy[COORD_W] ? 2'sb11 : 2'sb01);
        x_major_s = (adx >= ady);
        major_s   = x_major_s ? adx : ady;
        minor_s   = x_major_s ? ady : adx;
        err_init  = {2'b00, minor_s, 1'b0} - {3'b000, major_s};
    end

    // Candidate next pixel and error term from the current Bresenham state.
    logic             minor_go, last_s;
    coord_t           step_x, step_y, adv_x, adv_y;
    logic [ERR_W-1:0] two_minor, two_major, err_adv;

    always_comb begin
        minor_go  = ~err_q[ERR_W-1];
        two_minor = {2'b00, minor_q, 1'b0};
        two_major = {2'b00, major_q, 1'b0};
        err_adv   = minor_go ? (err_q + two_minor - two_major) : (err_q + two_minor);
        step_x    = step_coord(cur_x_q, sx_q);
        step_y    = step_coord(cur_y_q, sy_q);
        if (x_major_q) begin
            adv_x = step_x;
            adv_y = minor_go ? step_y : cur_y_q;
        end else begin
            adv_x = minor_go ? step_x : cur_x_q;
            adv_y = step_y;
        end
        last_s = (state_q == ST_STEP) && (cnt_q == '0);
    end

    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        major_d   = major_q;
        minor_d   = minor_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        x_major_d = x_major_q;
        done_d    = 1'b0;
        if (i_start) begin
            // A new line aborts whatever is in flight, including a final step.
            x0_d    = i_x0;
            y0_d    = i_y0;
            x1_d    = i_x1;
            y1_d    = i_y1;
            state_d = ST_SETUP;
        end else begin
            case (state_q)
                ST_SETUP: begin
                    cur_x_d   = x0_q;
                    cur_y_d   = y0_q;
                    err_d     = err_init;
                    cnt_d     = major_s;
                    major_d   = major_s;
                    minor_d   = minor_s;
                    sx_d      = sx_s;
                    sy_d      = sy_s;
                    x_major_d = x_major_s;
                    state_d   = ST_STEP;
                end
                ST_STEP: begin
                    if (i_step) begin
                        if (cnt_q == '0) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            cur_x_d = adv_x;
                            cur_y_d = adv_y;
                            err_d   = err_adv;
                            cnt_d   = cnt_q - 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state_q   <= ST_IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            err_q     <= '0;
            cnt_q     <= '0;
            major_q   <= '0;
            minor_q   <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            x_major_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            major_q   <= major_d;
            minor_q   <= minor_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            x_major_q <= x_major_d;
            done_q    <= done_d;
        end
    end

    nextX_t next_x;
    nextY_t next_y;

    always_comb begin
        next_x = (last_s || state_q != ST_STEP) ? cur_x_q : adv_x;
        next_y = (last_s || state_q != ST_STEP) ? cur_y_q : adv_y;
    end

    assign o_busy      = (state_q != ST_IDLE);
    assign o_valid     = (state_q == ST_STEP);
    assign o_last      = last_s;
    assign o_done      = done_q;
    assign o_lineX     = cur_x_q;
    assign o_lineY     = cur_y_q;
    assign o_nextLineX = next_x;
    assign o_nextLineY = next_y;

endmodule

// File: tb/tb_gpu_line_stepper.sv
// Self-checking bench for gpu_line_stepper: directed lines plus random short
// lines, compared against a closed-form rounding model of the rasterised line.
module tb_gpu_line_stepper;

    logic               i_clk = 1'b0;
    logic               i_nRst = 1'b0;
    logic               i_start = 1'b0;
    logic               i_step = 1'b0;
    logic signed [11:0] i_x0 = '0, i_y0 = '0, i_x1 = '0, i_y1 = '0;
    logic               o_busy, o_valid, o_last, o_done;
    logic signed [11:0] o_lineX, o_lineY, o_nextLineX, o_nextLineY;

    int checks = 0;
    int errors = 0;

    gpu_line_stepper dut (
        .i_clk       (i_clk),
        .i_nRst      (i_nRst),
        .i_start     (i_start),
        .i_x0        (i_x0),
        .i_y0        (i_y0),
        .i_x1        (i_x1),
        .i_y1        (i_y1),
        .i_step      (i_step),
        .o_busy      (o_busy),
        .o_valid     (o_valid),
        .o_lineX     (o_lineX),
        .o_lineY     (o_lineY),
        .o_nextLineX (o_nextLineX),
        .o_nextLineY (o_nextLineY),
        .o_last      (o_last),
        .o_done      (o_done)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int isgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    // Pixel k of the line: major axis advances by k, minor axis by
    // round-half-up(k*minor/major).
    function automatic void exp_pix(input int x0, input int y0, input int x1, input int y1,
                                    input int k, output int ex, output int ey);
        int adx, ady, mj, mn, off;
        adx = iabs(x1 - x0);
        ady = iabs(y1 - y0);
        mj  = (adx >= ady) ? adx : ady;
        mn  = (adx >= ady) ? ady : adx;
        off = (mj == 0) ? 0 : (2 * mn * k + mj) / (2 * mj);
        if (adx >= ady) begin
            ex = x0 + isgn(x1 - x0) * k;
            ey = y0 + isgn(y1 - y0) * off;
        end else begin
            ex = x0 + isgn(x1 - x0) * off;
            ey = y0 + isgn(y1 - y0) * k;
        end
    endfunction

    function automatic logic [31:0] c12(input int v);
        return {20'd0, 12'(v)};
    endfunction

    // Runs a line; abort_after >= 0 leaves after that many steps with i_step high.
    task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                            input int max_stall, input int abort_after);
        int mj, ex, ey, nx, ny, stall;
        mj = (iabs(x1 - x0) >= iabs(y1 - y0)) ? iabs(x1 - x0) : iabs(y1 - y0);
        i_x0 = 12'(x0);
        i_y0 = 12'(y0);
        i_x1 = 12'(x1);
        i_y1 = 12'(y1);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        i_step = 1'b1;
        chk("setup_busy", {31'd0, o_busy}, 32'd1);
        chk("setup_valid", {31'd0, o_valid}, 32'd0);
        chk("setup_done", {31'd0, o_done}, 32'd0);
        @(negedge i_clk);
        i_step = 1'b0;
        for (int k = 0; k <= mj; k++) begin
            if (abort_after >= 0 && k == abort_after) begin
                i_step = 1'b1;
                $display("line (%0d,%0d)->(%0d,%0d) aborted after %0d steps", x0, y0, x1, y1, k);
                return;
            end
            exp_pix(x0, y0, x1, y1, k, ex, ey);
            if (k == mj) begin
                nx = ex;
                ny = ey;
            end else begin
                exp_pix(x0, y0, x1, y1, k + 1, nx, ny);
            end
            stall = $urandom_range(0, max_stall);
            for (int s = 0; s <= stall; s++) begin
                chk("valid", {31'd0, o_valid}, 32'd1);
                chk("busy", {31'd0, o_busy}, 32'd1);
                chk("x", {20'd0, o_lineX}, c12(ex));
                chk("y", {20'd0, o_lineY}, c12(ey));
                chk("next_x", {20'd0, o_nextLineX}, c12(nx));
                chk("next_y", {20'd0, o_nextLineY}, c12(ny));
                chk("last", {31'd0, o_last}, {31'd0, k == mj});
                chk("done_early", {31'd0, o_done}, 32'd0);
                if (s < stall) @(negedge i_clk);
            end
            i_step = 1'b1;
            @(negedge i_clk);
            i_step = 1'b0;
        end
        chk("done_pulse", {31'd0, o_done}, 32'd1);
        chk("end_busy", {31'd0, o_busy}, 32'd0);
        chk("end_valid", {31'd0, o_valid}, 32'd0);
        chk("end_last", {31'd0, o_last}, 32'd0);
        @(negedge i_clk);
        chk("done_one_cycle", {31'd0, o_done}, 32'd0);
        $display("line (%0d,%0d)->(%0d,%0d) pixels=%0d", x0, y0, x1, y1, mj + 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
        chk({tag, "_last"}, {31'd0, o_last}, 32'd0);
        chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
        chk({tag, "_x"}, {20'd0, o_lineX}, 32'd0);
        chk({tag, "_y"}, {20'd0, o_lineY}, 32'd0);
        chk({tag, "_nx"}, {20'd0, o_nextLineX}, 32'd0);
        chk({tag, "_ny"}, {20'd0, o_nextLineY}, 32'd0);
    endtask

    initial begin
        int x0, y0, x1, y1, ox, oy;
        #12;
        chk_all_zero("reset");
        @(negedge i_clk);
        i_nRst = 1'b1;
        i_step = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("idle_step_valid", {31'd0, o_valid}, 32'd0);
        chk("idle_step_busy", {31'd0, o_busy}, 32'd0);
        i_step = 1'b0;

        run_line(0, 0, 3, 0, 0, -1);
        run_line(0, 0, 1, 3, 0, -1);
        run_line(5, 5, 3, 3, 1, -1);
        run_line(7, -2, 7, -2, 2, -1);
        run_line(-2048, 2047, -2040, 2044, 1, -1);

        // Restart mid-line with a simultaneous step; the first line must not finish.
        run_line(0, 0, 10, 0, 0, 2);
        run_line(2, 2, 2, 4, 0, -1);

        // Asynchronous reset mid-line, then a normal line right after release.
        run_line(0, 0, 10, 0, 0, 3);
        #2 i_nRst = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge i_clk);
        i_nRst = 1'b1;
        i_step = 1'b0;
        run_line(-5, 3, 4, -1, 1, -1);

        for (int n = 0; n < 24; n++) begin
            x0 = int'($urandom_range(0, 4095)) - 2048;
            y0 = int'($urandom_range(0, 4095)) - 2048;
            ox = int'($urandom_range(0, 40)) - 20;
            oy = int'($urandom_range(0, 40)) - 20;
            x1 = (x0 + ox > 2047 || x0 + ox < -2048) ? x0 - ox : x0 + ox;
            y1 = (y0 + oy > 2047 || y0 + oy < -2048) ? y0 - oy : y0 + oy;
            run_line(x0, y0, x1, y1, 2, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
